piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter built on a D-flip-flop shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per enabled clock, with a qualifying valid and an end-of-word pulse.
- Acts as the driving end of a serial bit link whose far end captures one bit per clock in a D-FF / SIPO chain.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous active-low reset (0 = reset).
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word.
- load_data  input  WIDTH  parallel word to send.
- shift_en  input  1  advance serial stream this cycle; 0 = stall.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a data (or parity) bit.
- busy  output  1  word in flight.
- done  output  1  one-cycle pulse after last bit.

Behaviour:
- All outputs registered; nothing combinational from inputs to outputs.
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT, (PARITY if PARITY_EN), DONE.
- IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1: capture load_data, drive ser_out = first bit, ser_valid=1, busy=1, load_ready=0, counter=1, go to SHIFT.
  - Latency: first bit is visible the cycle after acceptance.
- SHIFT:
  - shift_en=1 at a rising edge:
    - If counter<WIDTH: drive next bit, counter+1.
    - If counter==WIDTH: go to PARITY (if enabled), else clear ser_valid, ser_out<=0, done<=1, go to DONE.
  - shift_en=0: hold ser_out, ser_valid, counter and shift register unchanged. A stall may last any number of cycles.
  - Each bit is presented for exactly one enabled cycle. An unstalled word occupies WIDTH cycles with ser_valid=1.
- DONE:
  - Lasts exactly one cycle, regardless of shift_en. done=1, busy=1, load_ready=0.
  - Next edge: done=0, busy=0, load_ready=1, go to IDLE.
  - Minimum spacing between word starts is WIDTH+2 cycles (WIDTH+3 with parity).
- load_valid while load_ready=0 is ignored; the word is not queued.
- load_data changing after acceptance has no effect.
- Bit order:
  - LSB_FIRST=1: bits 0..WIDTH-1 in order.
  - LSB_FIRST=0: bits WIDTH-1..0.
- Reset asserted mid-word aborts immediately. No done pulse. After reset release, the block waits in IDLE.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, with shift_en=1, enter PARITY and drive ser_out = even parity (XOR of all WIDTH captured bits) with ser_valid=1.
  - The parity bit obeys the same shift_en stall rule.
  - The next enabled edge goes to DONE.
- Not defined: the PARITY state and parity logic are absent; SHIFT goes directly to DONE.

Test Plan:
- Reset then idle: rst=0 for 3 cycles mid-clock, release -> ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1 immediately on assertion.
- Basic LSB-first: WIDTH=8, load 8'hA5, shift_en=1 -> ser_out sequence 1,0,1,0,0,1,0,1 over 8 cycles with ser_valid=1. Then one done pulse, then load_ready=1 on the following cycle.
- MSB-first with stalls: LSB_FIRST=0, load 8'h81, shift_en low for 2 cycles after bit 2 -> sequence 1,0,0,0,0,0,0,1. Bit 2 is held for 3 cycles and no bit is lost.
- Busy rejection: assert load_valid with 8'hFF during SHIFT -> ignored. The original word completes; 8'hFF is sent only if load_valid is held into IDLE.
- Reset mid-word: rst=0 after 4 bits of 8'h3C -> all outputs cleared asynchronously and no done pulse. A fresh 8'h0F then transmits correctly.
- Parity (PISO_PARITY_EN): load 8'h07 -> 8 data bits followed by parity bit 1, done one cycle later. Load 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_shift_tx.sv
// ============================================================================
// piso_shift_tx -- parallel-in / serial-out transmitter
//
// Purpose:
//   Accepts a WIDTH-bit word through a valid/ready handshake and drives it
//   out one bit per enabled clock on ser_out, qualified by ser_valid. A
//   one-cycle done pulse follows the last bit. This is the driving end of a
//   serial bit link whose far end captures one bit per clock.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   LSB_FIRST  1 = bit 0 transmitted first, 0 = bit WIDTH-1 first
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = reset)
//   load_valid  load_data is valid
//   load_ready  block can accept a word (registered)
//   load_data   parallel word to send
//   shift_en    advance the serial stream this cycle; 0 = stall
//   ser_out     serial data bit (registered)
//   ser_valid   ser_out carries a data (or parity) bit (registered)
//   busy        word in flight (registered)
//   done        one-cycle pulse after the last bit (registered)
//
// Optional feature:
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of all captured
//                   data bits) is sent after the last data bit, subject to
//                   the same shift_en stall rule.
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t          state;
    logic [WIDTH-1:0] shreg;   // bits not yet driven, next one at the head
    logic [CW-1:0]    cnt;     // number of data bits already driven
`ifdef PISO_PARITY_EN
    logic             par;     // even parity of the captured word
`endif

    // Bit that leaves the register next, depending on transmit order.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Register contents after the head bit has been consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
    endfunction

    // NOTE: every registered signal uses non-blocking assignments so all
    // outputs update together from the pre-edge state; blocking here would
    // make the result depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // First bit goes out immediately; the register keeps
                        // only the bits still to be sent.
                        ser_out    <= head(load_data);
                        shreg      <= advance(load_data);
                        cnt        <= CW'(1);
                        ser_valid  <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef PISO_PARITY_EN
                        par        <= ^load_data;
`endif
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    // shift_en=0 leaves everything untouched (stall).
                    if (shift_en) begin
                        if (cnt != LAST_CNT) begin
                            ser_out <= head(shreg);
                            shreg   <= advance(shreg);
                            cnt     <= cnt + CW'(1);
                        end else begin
`ifdef PISO_PARITY_EN
                            ser_out <= par;
                            state   <= PARITY;
`else
                            ser_out   <= 1'b0;
                            ser_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end
                    end
                end

`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (shift_en) begin
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    // Single-cycle state, independent of shift_en.
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    cnt        <= '0;
                    state      <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    ser_out    <= 1'b0;
                    ser_valid  <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// ============================================================================
// tb_piso_shift_tx -- directed bench for piso_shift_tx
//
// Two instances share all inputs: u_lsb (LSB_FIRST=1) and u_msb
// (LSB_FIRST=0), so every word exercises both bit orders at once.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Define PISO_PARITY_EN to include the parity vectors.
// ============================================================================
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b0;

    logic l_ready, l_out, l_valid, l_busy, l_done;
    logic m_ready, m_out, m_valid, m_busy, m_done;

    int n_vec = 0;
    int n_bad = 0;

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(l_ready), .load_data(load_data),
        .shift_en(shift_en),
        .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy), .done(l_done)
    );

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(m_ready), .load_data(load_data),
        .shift_en(shift_en),
        .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy), .done(m_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status outputs of both instances against one expected tuple.
    task automatic chk_status(input string tag, input logic valid, input logic bsy,
                              input logic rdy, input logic dn);
        chk({tag, ".l_valid"}, 32'(l_valid), 32'(valid));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(valid));
        chk({tag, ".l_busy"},  32'(l_busy),  32'(bsy));
        chk({tag, ".m_busy"},  32'(m_busy),  32'(bsy));
        chk({tag, ".l_ready"}, 32'(l_ready), 32'(rdy));
        chk({tag, ".m_ready"}, 32'(m_ready), 32'(rdy));
        chk({tag, ".l_done"},  32'(l_done),  32'(dn));
        chk({tag, ".m_done"},  32'(m_done),  32'(dn));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".l_out"}, 32'(l_out), 32'd0);
        chk({tag, ".m_out"}, 32'(m_out), 32'd0);
        chk_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Send one word. stall_bit/stall_len: hold shift_en low for stall_len
    // cycles while bit index stall_bit is on the line (-1 = no stall).
    // reject=1 keeps load_valid high with 8'hFF for the whole word.
    task automatic send(input string tag, input logic [7:0] w, input int stall_bit,
                        input int stall_len, input bit reject);
        logic par_bit;
        par_bit    = ^w;
        load_data  = w;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();  // accepted here; first bit now visible
        if (reject) begin
            load_data = 8'hFF;
        end else begin
            load_valid = 1'b0;
            load_data  = ~w;  // must have no effect after acceptance
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.lsb_bit%0d", tag, i), 32'(l_out), 32'(w[i]));
            chk($sformatf("%s.msb_bit%0d", tag, i), 32'(m_out), 32'(w[7-i]));
            chk_status($sformatf("%s.b%0d", tag, i), 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == stall_bit) begin
                shift_en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk($sformatf("%s.hold_lsb%0d", tag, s), 32'(l_out), 32'(w[i]));
                    chk($sformatf("%s.hold_msb%0d", tag, s), 32'(m_out), 32'(w[7-i]));
                    chk_status($sformatf("%s.hold%0d", tag, s), 1'b1, 1'b1, 1'b0, 1'b0);
                end
                shift_en = 1'b1;
            end
            tick();
        end
`ifdef PISO_PARITY_EN
        chk({tag, ".l_parity"}, 32'(l_out), 32'(par_bit));
        chk({tag, ".m_parity"}, 32'(m_out), 32'(par_bit));
        chk_status({tag, ".par"}, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
`else
        par_bit = 1'b0;
`endif
        chk({tag, ".done_out"}, 32'(l_out), 32'(par_bit & 1'b0));
        chk_status({tag, ".done"}, 1'b0, 1'b1, 1'b0, 1'b1);
        shift_en = 1'b0;  // DONE must not depend on shift_en
        tick();
        chk_idle({tag, ".after"});
    endtask

    initial begin
        // Reset asserted mid-clock: outputs clear before any edge.
        #2 rst = 1'b0;
        #1 chk_idle("rst_async");
        repeat (3) @(posedge clk);
        #5 rst = 1'b1;  // release on the falling edge
        tick();
        chk_idle("rst_release");
        tick();
        chk_idle("idle_wait");

        // A5: LSB 1,0,1,0,0,1,0,1 ; MSB 1,0,1,0,0,1,0,1 (palindrome check)
        send("a5", 8'hA5, -1, 0, 1'b0);

        // 81 with 2-cycle stall on bit 2 (visible 3 cycles)
        send("81_stall", 8'h81, 2, 2, 1'b0);

        // 5A while FF is offered throughout; FF then goes out from IDLE
        send("5a_busy", 8'h5A, -1, 0, 1'b1);
        send("ff_next", 8'hFF, -1, 0, 1'b0);

        // Reset mid-word: 3C after 4 bits
        load_data  = 8'h3C;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("3c.lsb_bit0", 32'(l_out), 32'd0);
        chk("3c.msb_bit0", 32'(m_out), 32'd0);
        repeat (3) tick();
        chk("3c.lsb_bit3", 32'(l_out), 32'd1);
        chk("3c.msb_bit3", 32'(m_out), 32'd1);
        chk_status("3c.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 chk_idle("3c.rst_async");
        repeat (2) begin
            tick();
            chk_idle("3c.in_rst");
        end
        #3 rst = 1'b1;
        tick();
        chk_idle("3c.released");

        send("0f", 8'h0F, 5, 1, 1'b0);

`ifdef PISO_PARITY_EN
        send("par07", 8'h07, -1, 0, 1'b0);
        send("par03", 8'h03, 0, 3, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
